ahb_spi_master: RTL



---
 rtl/spi_pkg.sv | 41 ++++
 rtl/spi_shift_engine.sv | 118 +++++++++++
 rtl/ahb_spi_master.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/spi_pkg.sv
// Shared definitions for the AHB SPI master: register map, CTRL/STATUS bit positions, FSM states.
// No logic; no latency.
// No flow control.
package spi_pkg;

   localparam int SPI_BITS = 8;

   localparam logic [1:0] REG_CTRL   = 2'd0;
   localparam logic [1:0] REG_DATA   = 2'd1;
   localparam logic [1:0] REG_STATUS = 2'd2;

   localparam int CTRL_CPOL      = 8;
   localparam int CTRL_CPHA      = 9;
   localparam int CTRL_CSSEL_LSB = 10;
   localparam int CTRL_CSHOLD    = 13;
   localparam int CTRL_IRQEN     = 14;

   localparam int STAT_BUSY = 0;
   localparam int STAT_RXV  = 1;
   localparam int STAT_OVR  = 2;

   // Index of the final SCK edge in a byte (16 edges, counted from 0).
   localparam logic [3:0] EDGE_LAST = 4'(2 * SPI_BITS - 1);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_SETUP,
      ST_SHIFT,
      ST_HOLD
   } spi_state_t;

   typedef struct packed {
      logic       irqen;
      logic       cshold;
      logic [2:0] cssel;
      logic       cpha;
      logic       cpol;
      logic [7:0] div;
   } ctrl_t;

endpackage

// File: rtl/spi_shift_engine.sv
// SPI byte shifter: divider, SETUP/SHIFT/HOLD sequencing, SCK/MOSI/CS generation.
// Latency: busy for 18*(div+1) clk cycles from start; done pulses in the last busy cycle.
// No backpressure: start is only honoured while idle.
module spi_shift_engine
   import spi_pkg::*;
#(
   parameter int NCS = 4
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                start,
   input  logic [SPI_BITS-1:0] tx_byte,
   input  logic [7:0]          div,
   input  logic                cpol,
   input  logic                cpha,
   input  logic [2:0]          cssel,
   input  logic                cshold,
   input  logic                miso,
   output logic                busy,
   output logic                done,
   output logic [SPI_BITS-1:0] rx_byte,
   output logic                sck,
   output logic                mosi,
   output logic [NCS-1:0]      cs_n
);

   spi_state_t          state;
   spi_state_t          state_nxt;
   logic [7:0]          div_cnt;
   logic [3:0]          edge_cnt;
   logic [SPI_BITS-1:0] tx_sr;
   logic [SPI_BITS-1:0] rx_sr;
   logic [NCS-1:0]      cs_sel;
   logic                tick;
   logic                leading;

   assign tick    = (div_cnt == div);
   assign leading = ~edge_cnt[0];
   assign busy    = (state != ST_IDLE);
   assign rx_byte = rx_sr;

   // Out-of-range CSSEL leaves every chip select deasserted.
   always_comb begin
      cs_sel = '1;
      for (int i = 0; i < NCS; i++) begin
         cs_sel[i] = (int'(cssel) != i);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      done      = 1'b0;
      case (state)
         ST_IDLE:  if (start) state_nxt = ST_SETUP;
         ST_SETUP: if (tick) state_nxt = ST_SHIFT;
         ST_SHIFT: if (tick && edge_cnt == EDGE_LAST) state_nxt = ST_HOLD;
         ST_HOLD: begin
            if (tick) begin
               state_nxt = ST_IDLE;
               done      = 1'b1;
            end
         end
         default:  state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         div_cnt  <= '0;
         edge_cnt <= '0;
         tx_sr    <= '0;
         rx_sr    <= '0;
         sck      <= 1'b0;
         mosi     <= 1'b0;
         cs_n     <= '1;
      end else begin
         div_cnt <= (state == ST_IDLE || tick) ? 8'd0 : div_cnt + 8'd1;
         case (state)
            ST_IDLE: begin
               sck <= cpol;
               if (!cshold) cs_n <= '1;
               if (start) begin
                  tx_sr    <= tx_byte;
                  cs_n     <= cs_sel;
                  edge_cnt <= '0;
                  if (!cpha) mosi <= tx_byte[SPI_BITS-1];
               end
            end
            ST_SHIFT: begin
               if (tick) begin
                  sck      <= ~sck;
                  edge_cnt <= edge_cnt + 4'd1;
                  // Mode 0/2 samples on the leading edge, modes 1/3 launch on it.
                  if (leading == !cpha) begin
                     rx_sr <= {rx_sr[SPI_BITS-2:0], miso};
                  end else begin
                     tx_sr <= {tx_sr[SPI_BITS-2:0], 1'b0};
                     mosi  <= cpha ? tx_sr[SPI_BITS-1] : tx_sr[SPI_BITS-2];
                  end
               end
            end
            ST_HOLD: begin
               if (tick && !cshold) cs_n <= '1;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: rtl/ahb_spi_master.sv
// AHB-Lite slave with CTRL/DATA/STATUS registers driving a byte-wide SPI master; SPI_IRQ_EN adds SPI_IRQ and CTRL.IRQEN.
// Latency: zero wait states; writes land in the data-phase cycle, reads are combinational from the registered address.
// No backpressure: HREADYOUT is tied high; a DATA write while busy is dropped and flags OVR.
module ahb_spi_master
   import spi_pkg::*;
#(
   parameter int         NCS       = 4,
   parameter logic [7:0] DIV_RESET = 8'd3
) (
   input  logic           HCLK,
   input  logic           HRESET,
   input  logic           HSEL,
   input  logic [31:0]    HADDR,
   input  logic [1:0]     HTRANS,
   input  logic           HWRITE,
   input  logic [31:0]    HWDATA,
   output logic [31:0]    HRDATA,
   output logic           HREADYOUT,
   output logic           HRESP,
   output logic           SPI_SCK,
   output logic           SPI_MOSI,
   input  logic           SPI_MISO,
   output logic [NCS-1:0] SPI_CS_N
`ifdef SPI_IRQ_EN
   ,
   output logic           SPI_IRQ
`endif
);

`ifdef SPI_IRQ_EN
   localparam bit IRQ_BUILD = 1'b1;
`else
   localparam bit IRQ_BUILD = 1'b0;
`endif

   logic                dph_vld;
   logic                dph_wr;
   logic [1:0]          dph_addr;
   ctrl_t               ctrl_q;
   ctrl_t               ctrl_nxt;
   logic [SPI_BITS-1:0] rx_q;
   logic                rxv_q;
   logic                ovr_q;
   logic                busy;
   logic                done;
   logic [SPI_BITS-1:0] rx_byte;
   logic                wr_ctrl;
   logic                wr_data;
   logic                wr_status;
   logic                rd_data;
   logic [2:0]          status;
   logic                unused_ok;

   assign HREADYOUT = 1'b1;
   assign HRESP     = 1'b0;
   assign unused_ok = ^{HADDR[31:4], HADDR[1:0], HTRANS[0], HWDATA[31:15]};

   assign wr_ctrl   = dph_vld && dph_wr && dph_addr == REG_CTRL;
   assign wr_data   = dph_vld && dph_wr && dph_addr == REG_DATA;
   assign wr_status = dph_vld && dph_wr && dph_addr == REG_STATUS;
   assign rd_data   = dph_vld && !dph_wr && dph_addr == REG_DATA;

   always_ff @(posedge HCLK or posedge HRESET) begin
      if (HRESET) begin
         dph_vld  <= 1'b0;
         dph_wr   <= 1'b0;
         dph_addr <= '0;
      end else begin
         dph_vld  <= HSEL & HTRANS[1];
         dph_wr   <= HWRITE;
         dph_addr <= HADDR[3:2];
      end
   end

   // Only CSHOLD may change mid-transfer; the engine sees ctrl_nxt.cshold so a release lands next cycle.
   always_comb begin
      ctrl_nxt = ctrl_q;
      if (wr_ctrl) begin
         ctrl_nxt.cshold = HWDATA[CTRL_CSHOLD];
         if (!busy) begin
            ctrl_nxt.div   = HWDATA[7:0];
            ctrl_nxt.cpol  = HWDATA[CTRL_CPOL];
            ctrl_nxt.cpha  = HWDATA[CTRL_CPHA];
            ctrl_nxt.cssel = HWDATA[CTRL_CSSEL_LSB +: 3];
            ctrl_nxt.irqen = IRQ_BUILD & HWDATA[CTRL_IRQEN];
         end
      end
   end

   always_ff @(posedge HCLK or posedge HRESET) begin
      if (HRESET) begin
         ctrl_q <= '{irqen: 1'b0, cshold: 1'b0, cssel: 3'd0, cpha: 1'b0, cpol: 1'b0, div: DIV_RESET};
         rx_q   <= '0;
         rxv_q  <= 1'b0;
         ovr_q  <= 1'b0;
      end else begin
         ctrl_q <= ctrl_nxt;
         if (done) rx_q <= rx_byte;
         if (done) begin
            rxv_q <= 1'b1;
         end else if (rd_data) begin
            rxv_q <= 1'b0;
         end
         if ((wr_data && busy) || (done && rxv_q)) begin
            ovr_q <= 1'b1;
         end else if (wr_status && HWDATA[STAT_OVR]) begin
            ovr_q <= 1'b0;
         end
      end
   end

   always_comb begin
      status            = '0;
      status[STAT_BUSY] = busy;
      status[STAT_RXV]  = rxv_q;
      status[STAT_OVR]  = ovr_q;
   end

   always_comb begin
      HRDATA = '0;
      if (dph_vld && !dph_wr) begin
         case (dph_addr)
            REG_CTRL:   HRDATA = 32'(ctrl_q);
            REG_DATA:   HRDATA = 32'(rx_q);
            REG_STATUS: HRDATA = 32'(status);
            default:    HRDATA = '0;
         endcase
      end
   end

`ifdef SPI_IRQ_EN
   always_ff @(posedge HCLK or posedge HRESET) begin
      if (HRESET) begin
         SPI_IRQ <= 1'b0;
      end else begin
         SPI_IRQ <= ctrl_q.irqen & (rxv_q | ovr_q);
      end
   end
`endif

   spi_shift_engine #(
      .NCS (NCS)
   ) u_engine (
      .clk     (HCLK),
      .rst     (HRESET),
      .start   (wr_data && !busy),
      .tx_byte (HWDATA[SPI_BITS-1:0]),
      .div     (ctrl_q.div),
      .cpol    (ctrl_q.cpol),
      .cpha    (ctrl_q.cpha),
      .cssel   (ctrl_q.cssel),
      .cshold  (ctrl_nxt.cshold),
      .miso    (SPI_MISO),
      .busy    (busy),
      .done    (done),
      .rx_byte (rx_byte),
      .sck     (SPI_SCK),
      .mosi    (SPI_MOSI),
      .cs_n    (SPI_CS_N)
   );

endmodule
